// File: rtl/add8_sched.sv
// add8_sched: round-robin scheduler sharing a 32-lane saturating add8 datapath.
// Optional perf counters (perf_ops, perf_stall) enabled by ADD8_SCHED_PERF_EN.
module add8_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_src0,
  input  logic [NREQ*128-1:0] req_src1,
  input  logic [NREQ*128-1:0] req_src2,
  input  logic [NREQ*3-1:0]   req_sign,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [127:0]        res_dst0,
  output logic [127:0]        res_dst1,
`ifdef ADD8_SCHED_PERF_EN
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_stall,
`endif
  output logic [IDW-1:0]      res_id
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [127:0]   src0_q;
  logic [127:0]   src1_q;
  logic [127:0]   src2_q;
  logic [2:0]     sign_q;

  logic           win;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] rr_nxt;
  logic           hs;
  logic [127:0]   dst0_n;
  logic [127:0]   dst1_n;
  logic           unused_sign_s1;

  assign unused_sign_s1 = sign_q[1];

  assign win = (state == IDLE) || (state == HOLD && res_ready);

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(rr_ptr) + i) % NREQ;
      if (!gnt_any && req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(k);
      end
    end
  end

  assign rr_nxt    = IDW'((int'(gnt_id) + 1) % NREQ);
  assign hs        = win && gnt_any && !rst;
  assign req_ready = hs ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    logic signed [8:0] a;
    logic signed [8:0] b;
    logic signed [8:0] s;
    logic [7:0]        bv;
    logic [7:0]        clip;
    logic              sat;
    a      = '0;
    b      = '0;
    s      = '0;
    bv     = '0;
    clip   = '0;
    sat    = 1'b0;
    dst0_n = '0;
    dst1_n = '0;
    for (int i = 0; i < 32; i++) begin
      a    = sign_q[0] ? {{5{src0_q[i*4+3]}}, src0_q[i*4 +: 4]}
                       : {5'b0, src0_q[i*4 +: 4]};
      bv   = {src2_q[i*4 +: 4], src1_q[i*4 +: 4]};
      b    = sign_q[2] ? {bv[7], bv} : {1'b0, bv};
      s    = a + b;
      sat  = (a > 0 && b > 0 && s < 0) ||
             (a < 0 && b < 0 && s < -9'sd128);
      clip = sat ? 8'hFF : s[7:0];
      dst0_n[i*4 +: 4] = clip[3:0];
      dst1_n[i*4 +: 4] = clip[7:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      sign_q    <= '0;
      res_valid <= 1'b0;
      res_dst0  <= '0;
      res_dst1  <= '0;
      res_id    <= '0;
    end else begin
      if (hs) begin
        src0_q <= req_src0[int'(gnt_id)*128 +: 128];
        src1_q <= req_src1[int'(gnt_id)*128 +: 128];
        src2_q <= req_src2[int'(gnt_id)*128 +: 128];
        sign_q <= req_sign[int'(gnt_id)*3 +: 3];
        id_q   <= gnt_id;
        rr_ptr <= rr_nxt;
      end
      unique case (state)
        IDLE: if (hs) state <= EXEC;
        EXEC: begin
          res_dst0  <= dst0_n;
          res_dst1  <= dst1_n;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= hs ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADD8_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (hs)
        perf_ops <= perf_ops + 32'd1;
      if (state == HOLD && !res_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
